mvm_stream_driver: RTL and testbench

MVM_STREAM_DRIVER -- requirements
Module: mvm_stream_driver

---
 rtl/mvm_stream_driver.sv | 140 ++++++++++++++
 tb/tb_mvm_stream_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_stream_driver.sv
// mvm_stream_driver: streams NUM_TX signed bytes from a host-loaded transmit
// buffer to a downstream engine, then collects NUM_RX signed 16-bit results
// (with overflow flags) into a result buffer the host reads back.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The m_* side is registered: once m_valid rises it stays high and
// m_data stays stable until the transfer. The s_* side is accepted only in
// RECV (s_ready is a pure function of the state).
module mvm_stream_driver #(
   parameter int NUM_TX = 27,
   parameter int NUM_RX = 9
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_TX)-1:0]    wr_addr,
   input  logic signed [7:0]            wr_data,
   input  logic                         start,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [7:0]            m_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [15:0]           s_data,
   input  logic                         s_overflow,
   input  logic [$clog2(NUM_RX)-1:0]    rd_addr,
   output logic signed [15:0]           rd_data,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NUM_RX+1)-1:0]  ovf_count
);
   localparam int TXW = $clog2(NUM_TX);
   localparam int RXW = $clog2(NUM_RX);
   localparam int CW  = $clog2(NUM_RX + 1);
   localparam int FW  = $clog2(NUM_TX + 1);
   localparam logic [TXW-1:0] TX_LAST   = TXW'(NUM_TX - 1);
   localparam logic [RXW-1:0] RX_LAST   = RXW'(NUM_RX - 1);
   localparam logic [FW-1:0]  FETCH_END = FW'(NUM_TX);

   typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

   // state is kept as a plain named signal so checkers can bind to it
   state_t state;
   state_t state_next;

   logic signed [7:0]  tx_mem  [NUM_TX];
   logic signed [15:0] res_mem [NUM_RX];

   logic [TXW-1:0] tx_idx;     // words accepted downstream
   logic [RXW-1:0] rx_idx;     // results accepted
   logic [FW-1:0]  fetch_cnt;  // words read out of tx_mem so far

   logic launch;
   logic tx_hs;
   logic rx_hs;
   logic load_en;
   logic fetch_more;

   assign launch     = (state == IDLE) && start;
   assign tx_hs      = m_valid && m_ready;
   assign rx_hs      = s_valid && s_ready;
   assign fetch_more = (fetch_cnt != FETCH_END);
   // The read register doubles as the output register: reload it whenever it
   // is empty or its word is being taken, so words flow one per cycle.
   assign load_en    = (state == SEND) && (!m_valid || m_ready);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = (state == DONE);
      s_ready    = (state == RECV);
      case (state)
         IDLE: if (start) state_next = SEND;
         SEND: if (tx_hs && (tx_idx == TX_LAST)) state_next = RECV;
         RECV: if (rx_hs && (rx_idx == RX_LAST)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Host writes into the transmit buffer, allowed only while idle
   always_ff @(posedge clk) begin
      if (wr_en && (state == IDLE)) tx_mem[wr_addr] <= wr_data;
   end

   // Synchronous read of the transmit buffer into the outgoing word register
   always_ff @(posedge clk) begin
      if (load_en && fetch_more) m_data <= tx_mem[fetch_cnt[TXW-1:0]];
   end

   // Outgoing valid and fetch pointer; valid falls after the last word leaves
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid   <= 1'b0;
         fetch_cnt <= '0;
      end else if (launch) begin
         m_valid   <= 1'b0;
         fetch_cnt <= '0;
      end else if (load_en) begin
         m_valid <= fetch_more;
         if (fetch_more) fetch_cnt <= fetch_cnt + FW'(1);
      end else if (state != SEND) begin
         m_valid <= 1'b0;
      end
   end

   // Job counters: cleared by a launch, stepped by handshakes
   always_ff @(posedge clk) begin
      if (reset || launch) begin
         tx_idx    <= '0;
         rx_idx    <= '0;
         ovf_count <= '0;
      end else begin
         if (tx_hs && (tx_idx != TX_LAST)) tx_idx <= tx_idx + TXW'(1);
         if (rx_hs) begin
            if (rx_idx != RX_LAST) rx_idx <= rx_idx + RXW'(1);
            if (s_overflow) ovf_count <= ovf_count + CW'(1);
         end
      end
   end

   // Result buffer write on each accepted result
   always_ff @(posedge clk) begin
      if (rx_hs) res_mem[rx_idx] <= s_data;
   end

   // Registered result read port; a same-cycle write returns the old word
   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= res_mem[rd_addr];
   end

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Directed bench for mvm_stream_driver: streaming, backpressure, result
// collection with overflow counting, ignored inputs, and reset abort.
module tb_mvm_stream_driver;
   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               wr_en = 1'b0;
   logic [4:0]         wr_addr = '0;
   logic signed [7:0]  wr_data = '0;
   logic               start = 1'b0;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic signed [7:0]  m_data;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic signed [15:0] s_data = '0;
   logic               s_overflow = 1'b0;
   logic [3:0]         rd_addr = '0;
   logic signed [15:0] rd_data;
   logic               busy;
   logic               done;
   logic [3:0]         ovf_count;

   int errors = 0;
   int checks = 0;

   mvm_stream_driver dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_overflow(s_overflow), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .ovf_count(ovf_count)
   );

   // clock
   always #5 clk = ~clk;

   // advance one cycle; outputs are sampled 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_buffer();
      for (int i = 0; i < 27; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 8'(i + 1);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // feed nine results from RECV and return to IDLE
   task automatic drain_recv(input int base);
      for (int k = 0; k < 9; k++) begin
         s_valid = 1'b1; s_data = 16'(base + k); s_overflow = 1'b0;
         tick();
      end
      s_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL reset_ctrl: got v=%b r=%b d=%b b=%b required 0000", m_valid, s_ready, done, busy); end
      checks++;
      if (ovf_count !== 4'd0 || rd_data !== 16'sd0)
         begin errors++; $display("FAIL reset_regs: got ovf=%0d rd=%0d required 0 0", ovf_count, rd_data); end
   endtask

   task automatic test_backpressure();
      int exp_idx;
      int cyc;
      logic stalled;
      exp_idx = 0; cyc = 0; stalled = 1'b0;
      load_buffer();
      m_ready = 1'b0;
      pulse_start();
      while (exp_idx < 27 && cyc < 400) begin
         m_ready = (cyc % 2 == 0);
         if (stalled) begin
            checks++;
            if (m_valid !== 1'b1)
               begin errors++; $display("FAIL bp_valid_drop: got %b required 1 at word %0d", m_valid, exp_idx); end
         end
         if (m_valid === 1'b1) begin
            checks++;
            if (m_data !== 8'(exp_idx + 1))
               begin errors++; $display("FAIL bp_data: got %0d required %0d", m_data, exp_idx + 1); end
            if (m_ready) exp_idx++;
         end
         stalled = (m_valid === 1'b1) && !m_ready;
         tick();
         cyc++;
      end
      m_ready = 1'b1;
      checks++;
      if (exp_idx != 27)
         begin errors++; $display("FAIL bp_count: got %0d transfers required 27", exp_idx); end
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1)
         begin errors++; $display("FAIL bp_end: got v=%b r=%b required v=0 r=1", m_valid, s_ready); end
      drain_recv(500);
   endtask

   task automatic test_stream();
      m_ready = 1'b1;
      pulse_start();
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b1)
         begin errors++; $display("FAIL stream_c1: got v=%b b=%b required v=0 b=1", m_valid, busy); end
      tick();
      for (int k = 0; k < 27; k++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'(k + 1) || busy !== 1'b1)
            begin errors++; $display("FAIL stream_word: k=%0d got v=%b d=%0d b=%b required v=1 d=%0d b=1", k, m_valid, m_data, busy, k + 1); end
         tick();
      end
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1)
         begin errors++; $display("FAIL stream_end: got v=%b r=%b required v=0 r=1", m_valid, s_ready); end
   endtask

   task automatic test_results();
      for (int k = 0; k < 9; k++) begin
         s_valid = 1'b1; s_data = 16'(100 * k); s_overflow = (k == 2 || k == 5);
         checks++;
         if (s_ready !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL res_recv: k=%0d got r=%b d=%b required r=1 d=0", k, s_ready, done); end
         tick();
      end
      s_valid = 1'b0; s_overflow = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0)
         begin errors++; $display("FAIL res_done: got d=%b b=%b r=%b required 1 1 0", done, busy, s_ready); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL res_idle: got d=%b b=%b required 0 0", done, busy); end
      tick();
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0)
         begin errors++; $display("FAIL res_start_in_done: got b=%b v=%b required 0 0", busy, m_valid); end
      checks++;
      if (ovf_count !== 4'd2)
         begin errors++; $display("FAIL res_ovf: got %0d required 2", ovf_count); end
      for (int k = 0; k < 9; k++) begin
         rd_addr = 4'(k);
         tick();
         checks++;
         if (rd_data !== 16'(100 * k))
            begin errors++; $display("FAIL res_read: addr=%0d got %0d required %0d", k, rd_data, 100 * k); end
      end
      checks++;
      if (ovf_count !== 4'd2 || done !== 1'b0)
         begin errors++; $display("FAIL res_persist: got ovf=%0d d=%b required 2 0", ovf_count, done); end
   endtask

   task automatic test_ignore();
      int n;
      m_ready = 1'b1;
      pulse_start();
      s_valid = 1'b1; s_data = 16'h5555; s_overflow = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h7F;
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin tick(); n++; end
      s_valid = 1'b0; s_overflow = 1'b0; wr_en = 1'b0;
      checks++;
      if (n >= 100)
         begin errors++; $display("FAIL ign_reach_recv: got %0d cycles required < 100", n); end
      checks++;
      if (ovf_count !== 4'd0)
         begin errors++; $display("FAIL ign_ovf: got %0d required 0", ovf_count); end
      rd_addr = 4'd0;
      tick();
      checks++;
      if (rd_data !== 16'sd0)
         begin errors++; $display("FAIL ign_no_write: got %0d required 0", rd_data); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b1 || m_valid !== 1'b0)
         begin errors++; $display("FAIL ign_start_recv: got r=%b b=%b v=%b required 1 1 0", s_ready, busy, m_valid); end
      for (int k = 0; k < 9; k++) begin
         s_valid = 1'b1; s_data = 16'(1000 + k); rd_addr = 4'(k);
         tick();
         checks++;
         if (rd_data !== 16'(100 * k))
            begin errors++; $display("FAIL ign_old_data: addr=%0d got %0d required %0d", k, rd_data, 100 * k); end
      end
      s_valid = 1'b0;
      checks++;
      if (done !== 1'b1)
         begin errors++; $display("FAIL ign_done: got %b required 1", done); end
      for (int k = 0; k < 9; k++) begin
         rd_addr = 4'(k);
         tick();
         checks++;
         if (rd_data !== 16'(1000 + k))
            begin errors++; $display("FAIL ign_read: addr=%0d got %0d required %0d", k, rd_data, 1000 + k); end
      end
      checks++;
      if (ovf_count !== 4'd0 || busy !== 1'b0)
         begin errors++; $display("FAIL ign_final: got ovf=%0d b=%b required 0 0", ovf_count, busy); end
   endtask

   task automatic test_abort();
      int n;
      m_ready = 1'b1;
      pulse_start();
      tick();
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'sd11)
         begin errors++; $display("FAIL abort_pre: got v=%b d=%0d required v=1 d=11", m_valid, m_data); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0 || rd_data !== 16'sd0)
         begin errors++; $display("FAIL abort_reset: got b=%b v=%b d=%b r=%b rd=%0d required all 0", busy, m_valid, done, s_ready, rd_data); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL abort_no_done: got d=%b b=%b required 0 0", done, busy); end
      end
      pulse_start();
      checks++;
      if (m_valid !== 1'b0)
         begin errors++; $display("FAIL abort_restart_c1: got %b required 0", m_valid); end
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'sd1)
         begin errors++; $display("FAIL abort_first_word: got v=%b d=%0d required v=1 d=1", m_valid, m_data); end
      tick();
      checks++;
      if (m_data !== 8'sd2)
         begin errors++; $display("FAIL abort_second_word: got %0d required 2", m_data); end
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (n >= 100)
         begin errors++; $display("FAIL abort_reach_recv: got %0d cycles required < 100", n); end
      drain_recv(0);
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_stream();
      test_results();
      test_ignore();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
